mcb_port_responder: RTL and testbench

MCB_PORT_RESPONDER -- requirements
Module: mcb_port_responder

---
 rtl/mcb_port_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mcb_port_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_port_responder.sv
// MCB-style command/write/read port responder backed by a 2^MEM_AW x 32 memory.
// Define MCB_RESP_BYTE_MASK_EN to honour wr_mask per byte lane during WRITE_BURST.
module mcb_port_responder #(
  parameter int MEM_AW         = 10,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [27:0] cmd_addr,
  input  logic [5:0]  cmd_bl,
  output logic        cmd_rdy,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic [6:0]  wr_count,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic        rd_overflow,
  output logic        rd_error,
  output logic [6:0]  rd_count
);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
`ifdef MCB_RESP_BYTE_MASK_EN
  localparam int WF_W = 36;
`else
  localparam int WF_W = 32;
`endif
  localparam logic [6:0] FIFO_DEPTH = 7'd64;

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST, REFRESH} state_t;

  state_t            state_q, state_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [6:0]        len_q, len_d;
  logic [6:0]        beat_q, beat_d;
  logic [RW-1:0]     ref_q, ref_d;

  logic [WF_W-1:0]   wf_mem [64];
  logic [5:0]        wf_wp_q, wf_wp_d, wf_rp_q, wf_rp_d;
  logic [6:0]        wf_cnt_q, wf_cnt_d, wr_count_q, wr_count_d;
  logic [31:0]       rf_mem [64];
  logic [5:0]        rf_wp_q, rf_wp_d, rf_rp_q, rf_rp_d;
  logic [6:0]        rf_cnt_q, rf_cnt_d, rd_count_q, rd_count_d;
  logic              ovf_q, ovf_d, err_q, err_d;
  logic              rvld_q, rvld_d;
  logic [31:0]       rdata_q;

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] mem_idx;
  logic [WF_W-1:0]   wf_wr_entry, wf_head;
  logic [31:0]       wf_head_data;
  logic              wf_push, wf_pop, rf_push, rf_pop, rf_drop;
  logic              unused_in;

  assign unused_in = ^{cmd_addr, wr_mask};

`ifdef MCB_RESP_BYTE_MASK_EN
  logic [3:0] wf_head_mask;
  assign wf_wr_entry  = {wr_mask, wr_data};
  assign wf_head_mask = wf_head[35:32];
`else
  assign wf_wr_entry  = wr_data;
`endif
  assign wf_head      = wf_mem[wf_rp_q];
  assign wf_head_data = wf_head[31:0];

  assign wr_full  = (wf_cnt_q == FIFO_DEPTH);
  assign rd_full  = (rf_cnt_q == FIFO_DEPTH);
  assign rd_empty = (rf_cnt_q == 7'd0);
  assign rd_data  = rd_empty ? 32'd0 : rf_mem[rf_rp_q];
  assign cmd_rdy     = cmd_rdy_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;
  assign rd_overflow = ovf_q;
  assign rd_error    = err_q;

  // A pop frees a slot this cycle, so a push at full is accepted alongside it.
  assign wf_pop  = (state_q == WRITE_BURST) && (wf_cnt_q != 7'd0);
  assign wf_push = wr_en && (!wr_full || wf_pop);
  assign rf_pop  = rd_en && !rd_empty;
  assign rf_push = rvld_q && (!rd_full || rf_pop);
  assign rf_drop = rvld_q && rd_full && !rf_pop;
  assign mem_idx = addr_q + MEM_AW'(beat_q);

  always_comb begin
    state_d   = state_q;
    cmd_rdy_d = 1'b0;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ref_d     = ref_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_en && !cmd_rdy_q) begin
          cmd_rdy_d = 1'b1;
          addr_d    = cmd_addr[MEM_AW-1:0];
          len_d     = {1'b0, cmd_bl} + 7'd1;
          beat_d    = 7'd0;
          ref_d     = RW'(REFRESH_CYCLES - 1);
          case (cmd_instr)
            3'b000, 3'b010: state_d = WRITE_BURST;
            3'b001, 3'b011: state_d = READ_BURST;
            3'b100:         state_d = REFRESH;
            default:        state_d = IDLE;
          endcase
        end
      end
      WRITE_BURST: begin
        cmd_rdy_d = 1'b1;
        if (wf_pop) begin
          beat_d = beat_q + 7'd1;
          if (beat_q + 7'd1 == len_q) begin
            state_d   = IDLE;
            cmd_rdy_d = 1'b0;
          end
        end
      end
      READ_BURST: begin
        cmd_rdy_d = 1'b1;
        beat_d    = beat_q + 7'd1;
        if (beat_q + 7'd1 == len_q) begin
          state_d   = IDLE;
          cmd_rdy_d = 1'b0;
        end
      end
      REFRESH: begin
        cmd_rdy_d = 1'b1;
        if (ref_q == RW'(0)) begin
          state_d   = IDLE;
          cmd_rdy_d = 1'b0;
        end else begin
          ref_d = ref_q - RW'(1);
        end
      end
    endcase
  end

  always_comb begin
    rvld_d   = (state_q == READ_BURST);
    wf_wp_d  = wf_wp_q + 6'(wf_push);
    wf_rp_d  = wf_rp_q + 6'(wf_pop);
    rf_wp_d  = rf_wp_q + 6'(rf_push);
    rf_rp_d  = rf_rp_q + 6'(rf_pop);
    wf_cnt_d = wf_cnt_q;
    if (wf_push && !wf_pop)      wf_cnt_d = wf_cnt_q + 7'd1;
    else if (!wf_push && wf_pop) wf_cnt_d = wf_cnt_q - 7'd1;
    rf_cnt_d = rf_cnt_q;
    if (rf_push && !rf_pop)      rf_cnt_d = rf_cnt_q + 7'd1;
    else if (!rf_push && rf_pop) rf_cnt_d = rf_cnt_q - 7'd1;
    wr_count_d = wf_cnt_q;
    rd_count_d = rf_cnt_q;
    ovf_d      = ovf_q | rf_drop;
    err_d      = err_q | (rd_en && rd_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_rdy_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      ref_q      <= '0;
      wf_wp_q    <= '0;
      wf_rp_q    <= '0;
      wf_cnt_q   <= '0;
      wr_count_q <= '0;
      rf_wp_q    <= '0;
      rf_rp_q    <= '0;
      rf_cnt_q   <= '0;
      rd_count_q <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      rvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= cmd_rdy_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      ref_q      <= ref_d;
      wf_wp_q    <= wf_wp_d;
      wf_rp_q    <= wf_rp_d;
      wf_cnt_q   <= wf_cnt_d;
      wr_count_q <= wr_count_d;
      rf_wp_q    <= rf_wp_d;
      rf_rp_q    <= rf_rp_d;
      rf_cnt_q   <= rf_cnt_d;
      rd_count_q <= rd_count_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      rvld_q     <= rvld_d;
    end
  end

  // Storage arrays carry no reset so memory survives a mid-burst reset.
  always_ff @(posedge clk) begin
    if (wf_pop) begin
`ifdef MCB_RESP_BYTE_MASK_EN
      for (int b = 0; b < 4; b++) begin
        if (!wf_head_mask[b]) mem[mem_idx][8*b +: 8] <= wf_head_data[8*b +: 8];
      end
`else
      mem[mem_idx] <= wf_head_data;
`endif
    end
    if (state_q == READ_BURST) rdata_q <= mem[mem_idx];
    if (wf_push) wf_mem[wf_wp_q] <= wf_wr_entry;
    if (rf_push) rf_mem[rf_wp_q] <= rdata_q;
  end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed bench for mcb_port_responder: table of write/readback bursts plus
// hand sequences for latency, refresh, masking, FIFO limits and mid-burst reset.
module tb_mcb_port_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [27:0] cmd_addr;
  logic [5:0]  cmd_bl;
  logic        cmd_rdy;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [6:0]  wr_count;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty, rd_overflow, rd_error;
  logic [6:0]  rd_count;

  int checks   = 0;
  int failures = 0;

`ifdef MCB_RESP_BYTE_MASK_EN
  localparam logic [31:0] MASK_EXP = 32'h00FF00FF;
`else
  localparam logic [31:0] MASK_EXP = 32'h00000000;
`endif

  typedef struct {
    logic             do_wr;
    logic [2:0]       wi;
    logic [27:0]      wa;
    logic [5:0]       wbl;
    logic [3:0][31:0] wd;
    logic [2:0]       ri;
    logic [27:0]      ra;
    logic [5:0]       rbl;
    logic [3:0][31:0] ex;
  } vec_t;

  vec_t vt [5];

  mcb_port_responder dut (
    .clk(clk), .rst(rst),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_bl(cmd_bl),
    .cmd_rdy(cmd_rdy),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
    .wr_count(wr_count),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_error(rd_error), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] instr, input logic [27:0] addr, input logic [5:0] bl);
    cmd_en = 1'b1; cmd_instr = instr; cmd_addr = addr; cmd_bl = bl;
    step();
    cmd_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cmd_rdy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk({name, "_idle"}, 32'(cmd_rdy), 0);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk({name, "_empty"}, 32'(rd_empty), 0);
    chk({name, "_data"}, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_cmd_rdy"}, 32'(cmd_rdy), 0);
    chk({name, "_wr_full"}, 32'(wr_full), 0);
    chk({name, "_wr_count"}, 32'(wr_count), 0);
    chk({name, "_rd_empty"}, 32'(rd_empty), 1);
    chk({name, "_rd_full"}, 32'(rd_full), 0);
    chk({name, "_rd_count"}, 32'(rd_count), 0);
    chk({name, "_rd_overflow"}, 32'(rd_overflow), 0);
    chk({name, "_rd_error"}, 32'(rd_error), 0);
    chk({name, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    int n;
    cmd_en = 0; cmd_instr = 0; cmd_addr = 0; cmd_bl = 0;
    wr_en = 0; wr_mask = 0; wr_data = 0; rd_en = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    step();

    // {do_wr, wi, wa, wbl, wd[3:0], ri, ra, rbl, ex[3:0]}
    vt[0] = '{1'b1, 3'b010, 28'h10, 6'd3,
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
              3'b011, 28'h10, 6'd3,
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
    vt[1] = '{1'b1, 3'b000, 28'h3FE, 6'd3,
              {32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0},
              3'b001, 28'h3FE, 6'd3,
              {32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0}};
    vt[2] = '{1'b0, 3'b000, 28'h0, 6'd0, '0,
              3'b001, 28'h000, 6'd1,
              {32'h0, 32'h0, 32'hA0A0A0A3, 32'hA0A0A0A2}};
    vt[3] = '{1'b1, 3'b000, 28'h20, 6'd3,
              {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000},
              3'b001, 28'h21, 6'd1,
              {32'h0, 32'h0, 32'hB0000002, 32'hB0000001}};
    vt[4] = '{1'b1, 3'b010, 28'h0000405, 6'd0,
              {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
              3'b011, 28'h005, 6'd0,
              {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}};

    for (int r = 0; r < 5; r++) begin
      if (vt[r].do_wr) begin
        for (int i = 0; i <= int'(vt[r].wbl); i++) push(vt[r].wd[i], 4'b0000);
        issue(vt[r].wi, vt[r].wa, vt[r].wbl);
        wait_idle($sformatf("rec%0d_wr", r));
      end
      issue(vt[r].ri, vt[r].ra, vt[r].rbl);
      wait_idle($sformatf("rec%0d_rd", r));
      step();
      step();
      chk($sformatf("rec%0d_rd_count", r), 32'(rd_count), 32'(vt[r].rbl) + 1);
      for (int i = 0; i <= int'(vt[r].rbl); i++)
        pop_chk($sformatf("rec%0d_w%0d", r, i), vt[r].ex[i]);
      chk($sformatf("rec%0d_drained", r), 32'(rd_empty), 1);
      chk($sformatf("rec%0d_rd_error", r), 32'(rd_error), 0);
    end

    // Read latency: first word appears two cycles after acceptance.
    issue(3'b001, 28'h10, 6'd0);
    chk("lat_e0_cmd_rdy", 32'(cmd_rdy), 1);
    chk("lat_e0_empty", 32'(rd_empty), 1);
    step();
    chk("lat_e1_empty", 32'(rd_empty), 1);
    chk("lat_e1_cmd_rdy", 32'(cmd_rdy), 0);
    step();
    pop_chk("lat_e2", 32'h11111111);

    // Undefined instruction: busy for one cycle, no side effects.
    issue(3'b101, 28'h10, 6'd0);
    chk("bad_instr_busy", 32'(cmd_rdy), 1);
    step();
    chk("bad_instr_free", 32'(cmd_rdy), 0);
    step();
    step();
    chk("bad_instr_no_read", 32'(rd_empty), 1);

    // REFRESH: busy exactly 8 cycles; cmd_en held throughout must be ignored.
    issue(3'b100, 28'h0, 6'd0);
    n = 0;
    while (cmd_rdy === 1'b1 && n < 50) begin
      n++;
      cmd_en = 1'b1; cmd_instr = 3'b001; cmd_addr = 28'h10; cmd_bl = 6'd0;
      step();
    end
    cmd_en = 1'b0;
    chk("refresh_len", 32'(n), 8);
    repeat (4) step();
    chk("refresh_ignored_cmd", 32'(rd_empty), 1);
    chk("refresh_still_idle", 32'(cmd_rdy), 0);

    // Byte mask: bit high protects the lane.
    push(32'hFFFFFFFF, 4'b0000);
    issue(3'b000, 28'h40, 6'd0);
    wait_idle("mask_w1");
    push(32'h00000000, 4'b0101);
    issue(3'b000, 28'h40, 6'd0);
    wait_idle("mask_w2");
    issue(3'b001, 28'h40, 6'd0);
    wait_idle("mask_rd");
    step();
    step();
    pop_chk("mask", MASK_EXP);

    // Write FIFO fill to 64, 65th dropped, registered count lags by a cycle.
    push(32'h00001000, 4'b0000);
    chk("wr_count_lag", 32'(wr_count), 0);
    for (int i = 1; i < 64; i++) push(32'h00001000 + 32'(i), 4'b0000);
    chk("wr_full_exact", 32'(wr_full), 1);
    push(32'h0000BAD0, 4'b0000);
    chk("wr_count_64", 32'(wr_count), 64);
    chk("wr_full_hold", 32'(wr_full), 1);
    issue(3'b000, 28'h100, 6'd63);
    wait_idle("drain_wr");
    step();
    step();
    chk("wr_count_drained", 32'(wr_count), 0);
    chk("wr_full_drained", 32'(wr_full), 0);

    // Read FIFO overflow: 64 + 2 words pushed with no pops.
    issue(3'b001, 28'h100, 6'd63);
    wait_idle("ovf_rd1");
    chk("ovf_none_yet", 32'(rd_overflow), 0);
    issue(3'b001, 28'h100, 6'd1);
    wait_idle("ovf_rd2");
    step();
    step();
    chk("ovf_rd_full", 32'(rd_full), 1);
    chk("ovf_rd_count", 32'(rd_count), 64);
    chk("ovf_flag", 32'(rd_overflow), 1);
    for (int i = 0; i < 64; i++) pop_chk($sformatf("ovf_w%0d", i), 32'h00001000 + 32'(i));
    chk("ovf_drained", 32'(rd_empty), 1);
    step();
    chk("ovf_rd_count0", 32'(rd_count), 0);
    chk("ovf_sticky", 32'(rd_overflow), 1);
    chk("ovf_no_error", 32'(rd_error), 0);

    // Underflow pop: no data removed, sticky error.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("underflow_error", 32'(rd_error), 1);
    chk("underflow_empty", 32'(rd_empty), 1);
    step();
    chk("underflow_count", 32'(rd_count), 0);

    // Reset mid-WRITE_BURST after 2 of 8 words.
    issue(3'b001, 28'h10, 6'd0);
    wait_idle("pre_rst_rd");
    step();
    step();
    chk("pre_rst_rd_full_fifo", 32'(rd_empty), 0);
    push(32'hCAFE0000, 4'b0000);
    push(32'hCAFE0001, 4'b0000);
    issue(3'b000, 28'h200, 6'd7);
    repeat (4) step();
    chk("stall_busy", 32'(cmd_rdy), 1);
    chk("stall_wr_count", 32'(wr_count), 0);
    #3 rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #6 rst = 1'b1;
    step();
    issue(3'b001, 28'h200, 6'd1);
    wait_idle("post_rst_rd");
    step();
    step();
    pop_chk("retained0", 32'hCAFE0000);
    pop_chk("retained1", 32'hCAFE0001);
    chk("post_rst_error", 32'(rd_error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
